// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: hazard sources from the pipeline in, per-register stall/flush and PC redirect out.
// master = pipeline side, slave = the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int WORD = 32
);
  // Hazard sources
  logic            dcache_busy;
  logic            icache_busy;
  logic            icache_ready;
  logic            ex_mispredict;
  logic [WORD-1:0] ex_target;
  logic            id_pre_taken;
  logic [WORD-1:0] id_pre_target;
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;

  // Pipeline controls
  logic            pc_stall;
  logic            redirect_valid;
  logic [WORD-1:0] redirect_target;
  logic            if1_id_stall;
  logic            if1_id_flush;
  logic            id_ex_stall;
  logic            id_ex_flush;
  logic            ex_mem_stall;
  logic            icache_cancel;

  modport master (
    output dcache_busy, icache_busy, icache_ready,
    output ex_mispredict, ex_target, id_pre_taken, id_pre_target,
    output ex_is_load, ex_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  pc_stall, redirect_valid, redirect_target,
    input  if1_id_stall, if1_id_flush, id_ex_stall, id_ex_flush,
    input  ex_mem_stall, icache_cancel
  );

  modport slave (
    input  dcache_busy, icache_busy, icache_ready,
    input  ex_mispredict, ex_target, id_pre_taken, id_pre_target,
    input  ex_is_load, ex_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output pc_stall, redirect_valid, redirect_target,
    output if1_id_stall, if1_id_flush, id_ex_stall, id_ex_flush,
    output ex_mem_stall, icache_cancel
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for PC, IF1_ID, ID_EX and EX_MEM.
// Controls are combinational from state and inputs; state tracks deferred redirects, stale fetches and load-use bubbles.
module pipe_hazard_ctrl #(
  parameter int WORD             = 32,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HOLD_REDIR = 2'd1,
    DROP_FETCH = 2'd2
  } state_t;

  localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

  state_t          st;
  logic [WORD-1:0] redir_q;
  logic [1:0]      bub_cnt;

  logic hz;
  logic bub_active;
  logic stale_ready;

  always_comb begin
    hz = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
         ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
          (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));
    bub_active  = hz || (bub_cnt != 2'd0);
    stale_ready = (st == DROP_FETCH) && bus.icache_ready;
  end

  // Control outputs: one priority chain so a register never sees stall and flush together.
  always_comb begin
    // NOTE: every output gets a default first so no path through the chain can infer a latch.
    bus.pc_stall        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.if1_id_stall    = 1'b0;
    bus.if1_id_flush    = 1'b0;
    bus.id_ex_stall     = 1'b0;
    bus.id_ex_flush     = 1'b0;
    bus.ex_mem_stall    = 1'b0;
    bus.icache_cancel   = 1'b0;

    if (rst) begin
      bus.if1_id_flush = 1'b1;
      bus.id_ex_flush  = 1'b1;
    end else if (bus.dcache_busy) begin
      bus.pc_stall     = 1'b1;
      bus.if1_id_stall = 1'b1;
      bus.id_ex_stall  = 1'b1;
      bus.ex_mem_stall = 1'b1;
    end else if (st == HOLD_REDIR) begin
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = redir_q;
      bus.if1_id_flush    = 1'b1;
      bus.id_ex_flush     = 1'b1;
      bus.icache_cancel   = bus.icache_busy;
    end else if (bus.ex_mispredict) begin
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = bus.ex_target;
      bus.if1_id_flush    = 1'b1;
      bus.id_ex_flush     = 1'b1;
      bus.icache_cancel   = bus.icache_busy;
    end else if (bub_active) begin
      bus.pc_stall     = 1'b1;
      bus.if1_id_stall = 1'b1;
      bus.id_ex_flush  = 1'b1;
    end else if (bus.id_pre_taken) begin
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = bus.id_pre_target;
      bus.if1_id_flush    = 1'b1;
      bus.icache_cancel   = bus.icache_busy;
    end else if (stale_ready) begin
      // Response to a cancelled fetch: discard it and let the PC move on.
      bus.if1_id_flush = 1'b1;
    end else if (bus.icache_busy) begin
      bus.pc_stall     = 1'b1;
      bus.if1_id_flush = 1'b1;
    end
  end

  // State follows the same priority order as the outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      st      <= RUN;
      redir_q <= '0;
      bub_cnt <= 2'd0;
    end else if (bus.dcache_busy) begin
      // Older branch wins: the target is captured only on entry to HOLD_REDIR.
      if (bus.ex_mispredict && (st != HOLD_REDIR)) begin
        redir_q <= bus.ex_target;
        st      <= HOLD_REDIR;
      end
    end else if ((st == HOLD_REDIR) || bus.ex_mispredict) begin
      bub_cnt <= 2'd0;
      st      <= bus.icache_busy ? DROP_FETCH : RUN;
    end else if (bub_active) begin
      if (hz && (bub_cnt == 2'd0)) begin
        bub_cnt <= BUB_INIT;
      end else if (bub_cnt != 2'd0) begin
        bub_cnt <= bub_cnt - 2'd1;
      end
    end else if (bus.id_pre_taken) begin
      if (bus.icache_busy) begin
        st <= DROP_FETCH;
      end else if (stale_ready) begin
        st <= RUN;
      end
    end else if (stale_ready) begin
      st <= RUN;
    end
  end

endmodule
